// File: rtl/frame_source.sv
// Video-style frame stream source: emits FRAME_START, ROW_START, PIXEL, ROW_END and
// FRAME_END words with programmable geometry, row/frame blanking and a test pattern.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 3'd1
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 3'd2
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 3'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 3'd4
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 3'd5
`endif

module frame_source #(
    parameter int unsigned DIM_WIDTH   = 11,
    parameter int unsigned BLANK_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DIM_WIDTH-1:0]    num_cols,
    input  logic [DIM_WIDTH-1:0]    num_rows,
    input  logic [BLANK_WIDTH-1:0]  row_blank,
    input  logic [BLANK_WIDTH-1:0]  frame_blank,
    input  logic [1:0]              pattern,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [15:0]             datao,
    output logic                    busy
);
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE, FSTART, RSTART, PIX, REND, RBLANK, FEND, FBLANK
    } state_t;

    state_t                  state_q, state_d;
    logic [DIM_WIDTH-1:0]    cols_q, cols_d, rows_q, rows_d;
    logic [DIM_WIDTH-1:0]    col_q, col_d, row_q, row_d;
    logic [BLANK_WIDTH-1:0]  rb_q, rb_d, fb_q, fb_d, blk_q, blk_d;
    logic [1:0]              pat_q, pat_d;
    logic [DATA_W-1:0]       frame_q, frame_d, datao_q, datao_d, pix_data;
    logic [`DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
    logic                    dvo_q, dvo_d, busy_q;
    logic                    start_ok, frame_done, latch;

    assign dvo    = dvo_q;
    assign dtypeo = dtypeo_q;
    assign datao  = datao_q;
    assign busy   = busy_q;

    assign start_ok = enable && (num_cols != '0) && (num_rows != '0);

    // Pixel value for the current (row, column) under the latched pattern
    always_comb begin
        pix_data = '0;
        unique case (pat_q)
            2'd0:    pix_data = DATA_W'(col_q);
            2'd1:    pix_data = DATA_W'(row_q);
            2'd2:    pix_data = (row_q[3] ^ col_q[3]) ? 16'h03ff : 16'h0000;
            default: pix_data = 16'h0200;
        endcase
    end

    // Next-state, counters and the word to be registered on the outgoing edge
    always_comb begin
        state_d    = state_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        rb_d       = rb_q;
        fb_d       = fb_q;
        pat_d      = pat_q;
        col_d      = col_q;
        row_d      = row_q;
        blk_d      = blk_q;
        frame_d    = frame_q;
        dvo_d      = 1'b0;
        dtypeo_d   = dtypeo_q;
        datao_d    = datao_q;
        frame_done = 1'b0;
        latch      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = FSTART;
                    latch   = 1'b1;
                end
            end
            FSTART: begin
                dvo_d    = 1'b1;
                dtypeo_d = `DTYPE_FRAME_START;
                datao_d  = frame_q;
                frame_d  = frame_q + DATA_W'(1);
                row_d    = '0;
                state_d  = RSTART;
            end
            RSTART: begin
                dvo_d    = 1'b1;
                dtypeo_d = `DTYPE_ROW_START;
                datao_d  = DATA_W'(row_q);
                col_d    = '0;
                state_d  = PIX;
            end
            PIX: begin
                dvo_d    = 1'b1;
                dtypeo_d = `DTYPE_PIXEL;
                datao_d  = pix_data;
                if (col_q == cols_q - DIM_WIDTH'(1)) begin
                    state_d = REND;
                end else begin
                    col_d = col_q + DIM_WIDTH'(1);
                end
            end
            REND: begin
                dvo_d    = 1'b1;
                dtypeo_d = `DTYPE_ROW_END;
                datao_d  = '0;
                if (row_q == rows_q - DIM_WIDTH'(1)) begin
                    state_d = FEND;
                end else begin
                    row_d = row_q + DIM_WIDTH'(1);
                    if (rb_q != '0) begin
                        blk_d   = rb_q - BLANK_WIDTH'(1);
                        state_d = RBLANK;
                    end else begin
                        state_d = RSTART;
                    end
                end
            end
            RBLANK: begin
                if (blk_q == '0) begin
                    state_d = RSTART;
                end else begin
                    blk_d = blk_q - BLANK_WIDTH'(1);
                end
            end
            FEND: begin
                dvo_d    = 1'b1;
                dtypeo_d = `DTYPE_FRAME_END;
                datao_d  = '0;
                if (fb_q != '0) begin
                    blk_d   = fb_q - BLANK_WIDTH'(1);
                    state_d = FBLANK;
                end else begin
                    frame_done = 1'b1;
                end
            end
            FBLANK: begin
                if (blk_q == '0) begin
                    frame_done = 1'b1;
                end else begin
                    blk_d = blk_q - BLANK_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Back-to-back frames relatch configuration; a zero dimension parks in IDLE
        if (frame_done) begin
            if (start_ok) begin
                state_d = FSTART;
                latch   = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (latch) begin
            cols_d = num_cols;
            rows_d = num_rows;
            rb_d   = row_blank;
            fb_d   = frame_blank;
            pat_d  = pattern;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cols_q   <= '0;
            rows_q   <= '0;
            rb_q     <= '0;
            fb_q     <= '0;
            pat_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            blk_q    <= '0;
            frame_q  <= '0;
            dvo_q    <= 1'b0;
            dtypeo_q <= '0;
            datao_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cols_q   <= cols_d;
            rows_q   <= rows_d;
            rb_q     <= rb_d;
            fb_q     <= fb_d;
            pat_q    <= pat_d;
            col_q    <= col_d;
            row_q    <= row_d;
            blk_q    <= blk_d;
            frame_q  <= frame_d;
            dvo_q    <= dvo_d;
            dtypeo_q <= dtypeo_d;
            datao_q  <= datao_d;
            busy_q   <= (state_d != IDLE);
        end
    end

endmodule
